avalon_mem_if_reg_slice: RTL and testbench
==========================================

// Module: avalon_mem_if_reg_slice
//
// PURPOSE
// - Registered pipeline stage on the AFU side of an Avalon-MM local-memory path; its FIU-side
//   port drives the wire-level avalon_mem_if connect stage toward the memory bank.
// - Breaks timing on all request and response signals, including waitrequest, using a
//   2-entry skid buffer for requests and a registered read-response path.
// - Carries each beat independently, so burst handling and ordering are unchanged.
//
// PARAMETERS
// ADDR_WIDTH       27   word address width
// DATA_WIDTH       512  data width; byteenable width is DATA_WIDTH/8
// BURST_CNT_WIDTH  7    burstcount width
//
// PORTS
// clk                 in   1             clock
// reset_n             in   1             asynchronous active-low reset
// afu_waitrequest     out  1             registered stall to the AFU
// afu_read            in   1             read request
// afu_write           in   1             write beat
// afu_address         in   ADDR_WIDTH    address
// afu_burstcount      in   BURST_CNT_W   burst length
// afu_writedata       in   DATA_WIDTH    write data
// afu_byteenable      in   DATA_WIDTH/8  byte enables
// afu_readdata        out  DATA_WIDTH    read data
// afu_readdatavalid   out  1             read beat valid
// afu_bank_number     out  32            debug bank ID (registered copy of fiu_bank_number)
// fiu_waitrequest     in   1             stall from downstream
// fiu_read / fiu_write  out  1           request toward downstream
// fiu_address, fiu_burstcount, fiu_writedata, fiu_byteenable  out  (as afu_*)  request fields
// fiu_readdata        in   DATA_WIDTH    read data
// fiu_readdatavalid   in   1             read beat valid
// fiu_bank_number     in   32            debug bank ID
//
// BEHAVIOUR
// - Reset (async assert, sync release): afu_waitrequest=1; fiu_read=fiu_write=0;
//   afu_readdatavalid=0; all data/address/bank outputs=0; both buffer entries invalid.
//   afu_waitrequest falls on the first clk edge after reset_n rises.
// - Accept: an AFU beat is taken when (afu_read|afu_write) & !afu_waitrequest.
// - Issue: a FIU beat retires when (fiu_read|fiu_write) & !fiu_waitrequest.
// - FIU outputs always come from the MAIN register.
// - MAIN register stability: while fiu_waitrequest=1, all fiu_* outputs stay stable.
// - States:
//   - EMPTY: MAIN invalid.
//   - ONE: MAIN valid.
//   - TWO: MAIN and SKID valid.
// - Transitions:
//   - EMPTY + accept -> ONE.
//   - ONE: accept & retire -> ONE (MAIN reloads); accept & !retire -> TWO (beat into SKID);
//     retire & !accept -> EMPTY.
//   - TWO: retire -> ONE (SKID moves to MAIN); no accept is possible in TWO.
// - afu_waitrequest is a flop set to (next_state==TWO). This guarantees SKID is never
//   overwritten while valid.
// - Request latency: a beat accepted at edge N is visible on fiu_* after edge N, with no
//   downstream stall. Beats leave strictly in acceptance order.
// - Read response: fiu_readdata and fiu_readdatavalid are registered, 1 cycle latency. There
//   is no backpressure. fiu_bank_number is registered.
// - Illegal input: afu_read & afu_write in the same cycle is illegal. A simulation-only
//   assertion fires; the RTL gives write priority.
// - Mid-operation reset: all in-flight beats and responses are discarded.
//
// CONFIGURATION
// - AVALON_MEM_IF_RSP_PIPE2_EN
//   - Defined: a second response register stage is added, so read latency is 2 cycles. Bank
//     number is unaffected.
//   - Undefined: a single response stage, 1-cycle read latency.
//
// TESTING
// - Reset: hold reset_n=0 with random inputs -> afu_waitrequest=1, fiu_read/write=0,
//   afu_readdatavalid=0. One cycle after release -> afu_waitrequest=0.
// - Streaming: 8 write beats, addr 0x10..0x17, fiu_waitrequest=0 -> fiu_write on 8
//   consecutive cycles, each 1 cycle late, same order and data, afu_waitrequest stays 0.
// - Skid: fiu_waitrequest=1 from beat 2 of a continuous stream -> beats 1 and 2 held;
//   afu_waitrequest=1 the cycle after beat 2 is accepted; no beat lost or duplicated after
//   release.
// - Read response: fiu_readdatavalid pulse with data 0xA5.. -> afu_readdatavalid/afu_readdata
//   1 cycle later (2 cycles with AVALON_MEM_IF_RSP_PIPE2_EN).
// - Random: random fiu_waitrequest at 50% plus 1000 mixed read/write beats -> the scoreboard
//   matches the order and content of every beat.
// - Async reset: assert reset_n while in state TWO -> outputs return to reset values without
//   waiting for a clk edge.

Source files
------------

// File: rtl/avalon_mem_if_reg_slice.sv
// Registered Avalon-MM slice: 2-entry request skid buffer plus registered read response.
// Define AVALON_MEM_IF_RSP_PIPE2_EN to add a second read-response stage (2-cycle latency).
module avalon_mem_if_reg_slice #(
  parameter int unsigned ADDR_WIDTH      = 27,
  parameter int unsigned DATA_WIDTH      = 512,
  parameter int unsigned BURST_CNT_WIDTH = 7
) (
  input  logic                       clk,
  input  logic                       reset_n,
  // AFU side
  output logic                       afu_waitrequest,
  input  logic                       afu_read,
  input  logic                       afu_write,
  input  logic [ADDR_WIDTH-1:0]      afu_address,
  input  logic [BURST_CNT_WIDTH-1:0] afu_burstcount,
  input  logic [DATA_WIDTH-1:0]      afu_writedata,
  input  logic [DATA_WIDTH/8-1:0]    afu_byteenable,
  output logic [DATA_WIDTH-1:0]      afu_readdata,
  output logic                       afu_readdatavalid,
  output logic [31:0]                afu_bank_number,
  // FIU side
  input  logic                       fiu_waitrequest,
  output logic                       fiu_read,
  output logic                       fiu_write,
  output logic [ADDR_WIDTH-1:0]      fiu_address,
  output logic [BURST_CNT_WIDTH-1:0] fiu_burstcount,
  output logic [DATA_WIDTH-1:0]      fiu_writedata,
  output logic [DATA_WIDTH/8-1:0]    fiu_byteenable,
  input  logic [DATA_WIDTH-1:0]      fiu_readdata,
  input  logic                       fiu_readdatavalid,
  input  logic [31:0]                fiu_bank_number
);

  typedef struct packed {
    logic                       read;
    logic                       write;
    logic [ADDR_WIDTH-1:0]      address;
    logic [BURST_CNT_WIDTH-1:0] burstcount;
    logic [DATA_WIDTH-1:0]      writedata;
    logic [DATA_WIDTH/8-1:0]    byteenable;
  } beat_t;

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e state_q, state_d;
  beat_t  main_q, main_d;
  beat_t  skid_q, skid_d;
  beat_t  in_beat;
  logic   waitreq_q, waitreq_d;
  logic   accept, retire;

  always_comb begin
    in_beat.read       = afu_read & ~afu_write;  // write wins on an illegal read+write
    in_beat.write      = afu_write;
    in_beat.address    = afu_address;
    in_beat.burstcount = afu_burstcount;
    in_beat.writedata  = afu_writedata;
    in_beat.byteenable = afu_byteenable;

    accept = (afu_read | afu_write) & ~waitreq_q;
    retire = (main_q.read | main_q.write) & ~fiu_waitrequest;

    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          main_d  = in_beat;
          state_d = StOne;
        end
      end
      StOne: begin
        if (accept && retire) begin
          main_d = in_beat;
        end else if (accept) begin
          skid_d  = in_beat;
          state_d = StTwo;
        end else if (retire) begin
          main_d.read  = 1'b0;
          main_d.write = 1'b0;
          state_d      = StEmpty;
        end
      end
      StTwo: begin
        if (retire) begin
          main_d       = skid_q;
          skid_d.read  = 1'b0;
          skid_d.write = 1'b0;
          state_d      = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase

    // Stall is registered, so it must already be high when SKID becomes occupied.
    waitreq_d = (state_d == StTwo);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StEmpty;
      main_q    <= '0;
      skid_q    <= '0;
      waitreq_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      main_q    <= main_d;
      skid_q    <= skid_d;
      waitreq_q <= waitreq_d;
    end
  end

  assign afu_waitrequest = waitreq_q;
  assign fiu_read        = main_q.read;
  assign fiu_write       = main_q.write;
  assign fiu_address     = main_q.address;
  assign fiu_burstcount  = main_q.burstcount;
  assign fiu_writedata   = main_q.writedata;
  assign fiu_byteenable  = main_q.byteenable;

  // Read response path
  logic                  rsp_in_valid;
  logic [DATA_WIDTH-1:0] rsp_in_data;
  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;
  logic [31:0]           bank_q;

`ifdef AVALON_MEM_IF_RSP_PIPE2_EN
  logic                  rsp1_valid_q;
  logic [DATA_WIDTH-1:0] rsp1_data_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp1_valid_q <= 1'b0;
      rsp1_data_q  <= '0;
    end else begin
      rsp1_valid_q <= fiu_readdatavalid;
      rsp1_data_q  <= fiu_readdata;
    end
  end

  assign rsp_in_valid = rsp1_valid_q;
  assign rsp_in_data  = rsp1_data_q;
`else
  assign rsp_in_valid = fiu_readdatavalid;
  assign rsp_in_data  = fiu_readdata;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      bank_q      <= '0;
    end else begin
      rsp_valid_q <= rsp_in_valid;
      rsp_data_q  <= rsp_in_data;
      bank_q      <= fiu_bank_number;
    end
  end

  assign afu_readdatavalid = rsp_valid_q;
  assign afu_readdata      = rsp_data_q;
  assign afu_bank_number   = bank_q;

`ifndef SYNTHESIS
  rd_wr_exclusive: assert property (@(posedge clk) disable iff (!reset_n)
    !(afu_read && afu_write));
`endif

endmodule

// File: tb/tb_avalon_mem_if_reg_slice.sv
// Self-checking bench for avalon_mem_if_reg_slice: directed vector table plus reset,
// read-response, async-reset and randomized scoreboard sequences.
module tb_avalon_mem_if_reg_slice;

  localparam int unsigned AW = 27;
  localparam int unsigned DW = 512;
  localparam int unsigned BW = 7;
`ifdef AVALON_MEM_IF_RSP_PIPE2_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk;
  logic          reset_n;
  logic          afu_waitrequest;
  logic          afu_read, afu_write;
  logic [AW-1:0] afu_address;
  logic [BW-1:0] afu_burstcount;
  logic [DW-1:0] afu_writedata;
  logic [DW/8-1:0] afu_byteenable;
  logic [DW-1:0] afu_readdata;
  logic          afu_readdatavalid;
  logic [31:0]   afu_bank_number;
  logic          fiu_waitrequest;
  logic          fiu_read, fiu_write;
  logic [AW-1:0] fiu_address;
  logic [BW-1:0] fiu_burstcount;
  logic [DW-1:0] fiu_writedata;
  logic [DW/8-1:0] fiu_byteenable;
  logic [DW-1:0] fiu_readdata;
  logic          fiu_readdatavalid;
  logic [31:0]   fiu_bank_number;

  avalon_mem_if_reg_slice #(
    .ADDR_WIDTH      (AW),
    .DATA_WIDTH      (DW),
    .BURST_CNT_WIDTH (BW)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .afu_waitrequest   (afu_waitrequest),
    .afu_read          (afu_read),
    .afu_write         (afu_write),
    .afu_address       (afu_address),
    .afu_burstcount    (afu_burstcount),
    .afu_writedata     (afu_writedata),
    .afu_byteenable    (afu_byteenable),
    .afu_readdata      (afu_readdata),
    .afu_readdatavalid (afu_readdatavalid),
    .afu_bank_number   (afu_bank_number),
    .fiu_waitrequest   (fiu_waitrequest),
    .fiu_read          (fiu_read),
    .fiu_write         (fiu_write),
    .fiu_address       (fiu_address),
    .fiu_burstcount    (fiu_burstcount),
    .fiu_writedata     (fiu_writedata),
    .fiu_byteenable    (fiu_byteenable),
    .fiu_readdata      (fiu_readdata),
    .fiu_readdatavalid (fiu_readdatavalid),
    .fiu_bank_number   (fiu_bank_number)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rd;
    logic       wr;
    logic [7:0] addr;
    logic       fwait;
    logic       e_wait;
    logic       e_frd;
    logic       e_fwr;
    logic [7:0] e_addr;
  } vec_t;

  typedef struct packed {
    logic            read;
    logic            write;
    logic [AW-1:0]   address;
    logic [BW-1:0]   burstcount;
    logic [DW-1:0]   writedata;
    logic [DW/8-1:0] byteenable;
  } beat_t;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] wdata_of(input logic [7:0] a);
    return {16{24'hD00D00, a}};
  endfunction

  function automatic vec_t mkv(input logic rd, input logic wr, input logic [7:0] addr,
                               input logic fwait, input logic e_wait, input logic e_frd,
                               input logic e_fwr, input logic [7:0] e_addr);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.fwait = fwait;
    v.e_wait = e_wait; v.e_frd = e_frd; v.e_fwr = e_fwr; v.e_addr = e_addr;
    return v;
  endfunction

  function automatic beat_t rand_beat();
    beat_t b;
    b.read       = 1'($urandom_range(0, 1));
    b.write      = ~b.read;
    b.address    = AW'($urandom());
    b.burstcount = BW'($urandom());
    for (int k = 0; k < DW / 32; k++) b.writedata[32*k +: 32] = $urandom();
    b.byteenable = {$urandom(), $urandom()};
    return b;
  endfunction

  task automatic drive_beat(input beat_t b, input logic v);
    afu_read       = v & b.read;
    afu_write      = v & b.write;
    afu_address    = b.address;
    afu_burstcount = b.burstcount;
    afu_writedata  = b.writedata;
    afu_byteenable = b.byteenable;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t  vecs[18];
  beat_t cur, e, act;
  logic  cur_valid, acc, ret;
  beat_t exp_q[$];
  int    sent, cyc;

  initial begin
    for (int i = 0; i < 8; i++)
      vecs[i] = mkv(1'b0, 1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0, 1'b1, 8'(8'h10 + i));
    vecs[8]  = mkv(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    vecs[9]  = mkv(1'b0, 1'b1, 8'h20, 1'b0, 1'b0, 1'b0, 1'b1, 8'h20);
    vecs[10] = mkv(1'b0, 1'b1, 8'h21, 1'b1, 1'b1, 1'b0, 1'b1, 8'h20);
    vecs[11] = mkv(1'b0, 1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 1'b1, 8'h20);
    vecs[12] = mkv(1'b0, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 8'h21);
    vecs[13] = mkv(1'b0, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 8'h22);
    vecs[14] = mkv(1'b1, 1'b0, 8'h30, 1'b1, 1'b1, 1'b0, 1'b1, 8'h22);
    vecs[15] = mkv(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h30);
    vecs[16] = mkv(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h30);
    vecs[17] = mkv(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

    afu_read = 0; afu_write = 0; afu_address = '0; afu_burstcount = '0;
    afu_writedata = '0; afu_byteenable = '0; fiu_waitrequest = 0;
    fiu_readdata = '0; fiu_readdatavalid = 0; fiu_bank_number = '0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;

    // Reset held with random inputs
    for (int c = 0; c < 3; c++) begin
      afu_read          = 1'($urandom_range(0, 1));
      afu_write         = ~afu_read & 1'($urandom_range(0, 1));
      afu_address       = AW'($urandom());
      fiu_waitrequest   = 1'($urandom_range(0, 1));
      fiu_readdatavalid = 1'($urandom_range(0, 1));
      fiu_readdata      = {16{$urandom()}};
      fiu_bank_number   = $urandom();
      tick();
      check($sformatf("rst%0d_wait", c), afu_waitrequest, 1'b1);
      check($sformatf("rst%0d_fiu_read", c), fiu_read, 1'b0);
      check($sformatf("rst%0d_fiu_write", c), fiu_write, 1'b0);
      check($sformatf("rst%0d_rvalid", c), afu_readdatavalid, 1'b0);
      check($sformatf("rst%0d_bank", c), afu_bank_number, 32'h0);
    end
    afu_read = 0; afu_write = 0; fiu_waitrequest = 0;
    fiu_readdatavalid = 0; fiu_readdata = '0; fiu_bank_number = '0;
    @(negedge clk);
    reset_n = 1'b1;
    #1 check("rel_wait_before_edge", afu_waitrequest, 1'b1);
    tick();
    check("rel_wait_after_edge", afu_waitrequest, 1'b0);

    // Directed table: streaming then skid
    for (int i = 0; i < 18; i++) begin
      afu_read        = vecs[i].rd;
      afu_write       = vecs[i].wr;
      afu_address     = AW'(vecs[i].addr);
      afu_writedata   = wdata_of(vecs[i].addr);
      afu_byteenable  = '1;
      afu_burstcount  = BW'(1);
      fiu_waitrequest = vecs[i].fwait;
      tick();
      check($sformatf("vec%0d_wait", i), afu_waitrequest, vecs[i].e_wait);
      check($sformatf("vec%0d_fiu_read", i), fiu_read, vecs[i].e_frd);
      check($sformatf("vec%0d_fiu_write", i), fiu_write, vecs[i].e_fwr);
      if (vecs[i].e_frd || vecs[i].e_fwr)
        check($sformatf("vec%0d_addr", i), fiu_address, AW'(vecs[i].e_addr));
      if (vecs[i].e_fwr)
        check($sformatf("vec%0d_wdata", i), fiu_writedata, wdata_of(vecs[i].e_addr));
    end
    afu_read = 0; afu_write = 0; fiu_waitrequest = 0;

    // Read response pulse and bank number
    fiu_readdatavalid = 1'b1;
    fiu_readdata      = {64{8'hA5}};
    fiu_bank_number   = 32'hCAFE_0003;
    for (int c = 1; c <= 3; c++) begin
      tick();
      fiu_readdatavalid = 1'b0;
      fiu_readdata      = '0;
      check($sformatf("rsp_c%0d_valid", c), afu_readdatavalid, (c == LAT));
      if (c == LAT) check("rsp_data", afu_readdata, {64{8'hA5}});
      if (c == 1) check("bank_number", afu_bank_number, 32'hCAFE_0003);
    end

    // Async reset while in TWO
    afu_write = 1'b1; afu_address = AW'(8'h40); afu_writedata = wdata_of(8'h40);
    fiu_waitrequest = 1'b0;
    tick();
    afu_address = AW'(8'h41); afu_writedata = wdata_of(8'h41);
    fiu_waitrequest = 1'b1;
    tick();
    check("two_wait", afu_waitrequest, 1'b1);
    afu_write = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("arst_wait", afu_waitrequest, 1'b1);
    check("arst_fiu_write", fiu_write, 1'b0);
    check("arst_fiu_read", fiu_read, 1'b0);
    check("arst_fiu_addr", fiu_address, '0);
    check("arst_bank", afu_bank_number, 32'h0);
    fiu_waitrequest = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    check("arst_release_wait", afu_waitrequest, 1'b0);
    check("arst_no_stale_beat", fiu_write, 1'b0);

    // Random traffic against a FIFO scoreboard
    sent = 0; cyc = 0;
    cur = rand_beat(); cur_valid = 1'b1;
    drive_beat(cur, cur_valid);
    fiu_waitrequest = 1'($urandom_range(0, 1));
    while ((sent < 1000 || exp_q.size() > 0) && cyc < 20000) begin
      acc = cur_valid && !afu_waitrequest;
      ret = (fiu_read || fiu_write) && !fiu_waitrequest;
      if (ret) begin
        act.read = fiu_read; act.write = fiu_write; act.address = fiu_address;
        act.burstcount = fiu_burstcount; act.writedata = fiu_writedata;
        act.byteenable = fiu_byteenable;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL rand_extra_beat actual addr=%h expected none", act.address);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin
            failures++;
            $display("FAIL rand_beat actual rw=%b%b addr=%h bc=%h wd=%h be=%h expected rw=%b%b addr=%h bc=%h wd=%h be=%h",
                     act.read, act.write, act.address, act.burstcount, act.writedata[63:0],
                     act.byteenable[15:0], e.read, e.write, e.address, e.burstcount,
                     e.writedata[63:0], e.byteenable[15:0]);
          end
        end
      end
      if (acc) begin
        exp_q.push_back(cur);
        sent++;
      end
      tick();
      cyc++;
      if (acc || !cur_valid) begin
        if (sent < 1000 && $urandom_range(0, 3) != 0) begin
          cur = rand_beat(); cur_valid = 1'b1;
        end else begin
          cur_valid = 1'b0;
        end
      end
      drive_beat(cur, cur_valid);
      fiu_waitrequest = (sent >= 1000) ? 1'b0 : 1'($urandom_range(0, 1));
    end
    check("rand_no_timeout", (cyc < 20000), 1'b1);
    check("rand_all_sent", sent, 1000);
    check("rand_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
